perf_dump_ctrl: RTL and testbench

PERF_DUMP_CTRL -- requirements
Module: perf_dump_ctrl

---
 rtl/perf_dump_ctrl.sv | 166 ++++++++++++++++
 tb/tb_perf_dump_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/perf_dump_ctrl.sv
`default_nettype none
// ============================================================================
// perf_dump_ctrl : freezes the counter bank and streams a SYNC + counters frame
// to a byte UART. Optional trailing XOR checksum byte: PERF_DUMP_CKSUM_EN.
// Rev 1.0
// ============================================================================
module perf_dump_ctrl #(
  parameter int unsigned NUM_CNT   = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dump_req,
  output logic [3:0]  cnt_sel,
  input  logic [31:0] cnt_val,
  output logic        cnt_freeze,
  output logic [7:0]  tx_byte,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SEND  = 3'd2,
    S_ACK   = 3'd3,
    S_DRAIN = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  // Byte pointer: 0 = header, 1..4*NUM_CNT = counter bytes, then checksum.
  localparam logic [6:0] LAST_CNT_PTR = 7'(4 * NUM_CNT);
`ifdef PERF_DUMP_CKSUM_EN
  localparam logic [6:0] LAST_PTR     = 7'(4 * NUM_CNT + 1);
`else
  localparam logic [6:0] LAST_PTR     = 7'(4 * NUM_CNT);
`endif

  state_t      state_q;
  logic [6:0]  ptr_q, ptr_d;
  logic [6:0]  lane_ptr;
  logic [31:0] shadow_q;
  logic [3:0]  timer_q;
  logic [3:0]  cnt_sel_q;
  logic [7:0]  tx_byte_q;
  logic        tx_start_q;
  logic        busy_q;
  logic        freeze_q;
  logic        done_q;
  logic [7:0]  cur_byte;
`ifdef PERF_DUMP_CKSUM_EN
  logic [7:0]  cksum_q;
`endif

  always_comb begin
    ptr_d    = ptr_q + 7'd1;
    lane_ptr = ptr_q - 7'd1;
    cur_byte = SYNC_BYTE;
    if (ptr_q != 7'd0) begin
      case (lane_ptr[1:0])
        2'd0:    cur_byte = shadow_q[31:24];
        2'd1:    cur_byte = shadow_q[23:16];
        2'd2:    cur_byte = shadow_q[15:8];
        default: cur_byte = shadow_q[7:0];
      endcase
    end
`ifdef PERF_DUMP_CKSUM_EN
    if (ptr_q == LAST_PTR) cur_byte = cksum_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= 7'd0;
      shadow_q   <= 32'd0;
      timer_q    <= 4'd0;
      cnt_sel_q  <= 4'd0;
      tx_byte_q  <= 8'd0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      freeze_q   <= 1'b0;
      done_q     <= 1'b0;
`ifdef PERF_DUMP_CKSUM_EN
      cksum_q    <= 8'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dump_req) begin
            state_q   <= S_SEND;
            ptr_q     <= 7'd0;
            cnt_sel_q <= 4'd0;
            timer_q   <= 4'd0;
            busy_q    <= 1'b1;
            freeze_q  <= 1'b1;
`ifdef PERF_DUMP_CKSUM_EN
            cksum_q   <= 8'd0;
`endif
          end
        end
        S_LOAD: begin
          shadow_q  <= cnt_val;
          cnt_sel_q <= cnt_sel_q + 4'd1;
`ifdef PERF_DUMP_CKSUM_EN
          cksum_q   <= cksum_q ^ cnt_val[31:24] ^ cnt_val[23:16] ^ cnt_val[15:8] ^ cnt_val[7:0];
`endif
          state_q   <= S_SEND;
        end
        S_SEND: begin
          if (!tx_busy) begin
            tx_start_q <= 1'b1;
            tx_byte_q  <= cur_byte;
            timer_q    <= 4'd0;
            state_q    <= S_ACK;
          end
        end
        S_ACK: begin
          tx_start_q <= 1'b0;
          if (tx_busy) begin
            state_q <= S_DRAIN;
          end else if (timer_q == 4'd15) begin
            // Launch never acknowledged: resend the same byte.
            timer_q <= 4'd0;
            state_q <= S_SEND;
          end else begin
            timer_q <= timer_q + 4'd1;
          end
        end
        S_DRAIN: begin
          if (!tx_busy) begin
            if (ptr_q == LAST_PTR) begin
              state_q   <= S_FIN;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              freeze_q  <= 1'b0;
              cnt_sel_q <= 4'd0;
            end else begin
              ptr_q <= ptr_d;
              if (ptr_d <= LAST_CNT_PTR && ptr_d[1:0] == 2'b01)
                state_q <= S_LOAD;
              else
                state_q <= S_SEND;
            end
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cnt_sel    = cnt_sel_q;
  assign cnt_freeze = freeze_q;
  assign tx_byte    = tx_byte_q;
  assign tx_start   = tx_start_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_perf_dump_ctrl.sv
`default_nettype none
// ============================================================================
// tb_perf_dump_ctrl : frame-level bench for perf_dump_ctrl with a UART model.
// Rev 1.0
// ============================================================================
module tb_perf_dump_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        dump_req;
  logic [3:0]  cnt_sel;
  logic [31:0] cnt_val;
  logic        cnt_freeze;
  logic [7:0]  tx_byte;
  logic        tx_start;
  logic        tx_busy;
  logic        busy;
  logic        done;

  logic [31:0] bank [16];
  logic [7:0]  rx_q [$];
  logic [7:0]  exp_q [$];
  int          uart_cnt  = 0;
  int          busy_len  = 10;
  int          launch_tot = 0;
  int          drop_at   = 0;
  int          n_checks  = 0;
  int          n_fail    = 0;

  perf_dump_ctrl #(.NUM_CNT(8), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .dump_req(dump_req), .cnt_sel(cnt_sel), .cnt_val(cnt_val),
    .cnt_freeze(cnt_freeze), .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign cnt_val = bank[cnt_sel];
  assign tx_busy = (uart_cnt != 0);

  // UART: accepts a launch unless it is the one chosen to be lost.
  always @(posedge clk) begin
    if (tx_start) begin
      launch_tot = launch_tot + 1;
      if (launch_tot != drop_at) begin
        rx_q.push_back(tx_byte);
        uart_cnt <= busy_len;
      end
    end else if (uart_cnt != 0) begin
      uart_cnt <= uart_cnt - 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference frame: header, counters MSB first, optional XOR of payload bytes.
  task automatic build_exp();
    logic [7:0] ck;
    logic [7:0] b;
    exp_q = {};
    ck = 8'h00;
    exp_q.push_back(8'hA5);
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) begin
        b = 8'((bank[k] >> (24 - 8 * j)) & 32'hFF);
        exp_q.push_back(b);
        ck = ck ^ b;
      end
    end
`ifdef PERF_DUMP_CKSUM_EN
    exp_q.push_back(ck);
`endif
  endtask

  task automatic run_frame(input int drop_rel, input int mid_at, input int tamper_k,
                           input bit fin_req, output logic [7:0] last_b);
    int  base_l, base_rx, done_cnt, freeze_bad, prev_sel, n_rx;
    bit  fin, mid_fired;
    build_exp();
    base_l     = launch_tot;
    base_rx    = rx_q.size();
    drop_at    = (drop_rel != 0) ? launch_tot + drop_rel : 0;
    done_cnt   = 0;
    freeze_bad = 0;
    fin        = 1'b0;
    mid_fired  = 1'b0;
    prev_sel   = 0;
    last_b     = 8'h00;
    @(negedge clk);
    dump_req = 1'b1;
    for (int c = 0; c < 8000 && !fin; c++) begin
      @(negedge clk);
      dump_req = 1'b0;
      if (busy && !cnt_freeze) freeze_bad++;
      if (done) begin
        done_cnt++;
        fin = 1'b1;
        if (fin_req) dump_req = 1'b1;
      end
      if (mid_at != 0 && !mid_fired && (launch_tot - base_l) == mid_at) begin
        dump_req  = 1'b1;
        mid_fired = 1'b1;
      end
      if (int'(cnt_sel) != prev_sel && prev_sel == tamper_k) bank[tamper_k] = 32'hDEAD_BEEF;
      prev_sel = int'(cnt_sel);
    end
    check_val("frame_done_seen", 32'(fin), 32'd1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      dump_req = 1'b0;
      if (done) done_cnt++;
    end
    n_rx = rx_q.size() - base_rx;
    check_val("byte_count", n_rx, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n_rx; i++)
      check_val($sformatf("byte[%0d]", i), rx_q[base_rx + i], exp_q[i]);
    if (n_rx > 0) last_b = rx_q[rx_q.size() - 1];
    check_val("launches", launch_tot - base_l, exp_q.size() + ((drop_rel != 0) ? 1 : 0));
    check_val("done_pulses", done_cnt, 1);
    check_val("freeze_gap", freeze_bad, 0);
    check_val("busy_after", busy, 1'b0);
    check_val("freeze_after", cnt_freeze, 1'b0);
    check_val("cnt_sel_after", cnt_sel, 4'd0);
    drop_at = 0;
  endtask

  initial begin
    logic [7:0] lb;
    int base_l, aborted_done;
    rst      = 1'b1;
    dump_req = 1'b0;
    for (int k = 0; k < 16; k++) bank[k] = 32'h0000_0100 * k;
    repeat (3) @(negedge clk);
    check_val("rst_tx_start", tx_start, 1'b0);
    check_val("rst_tx_byte", tx_byte, 8'h00);
    check_val("rst_cnt_sel", cnt_sel, 4'd0);
    check_val("rst_freeze", cnt_freeze, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_frame(0, 0, -1, 1'b0, lb);
`ifdef PERF_DUMP_CKSUM_EN
    check_val("cksum_ramp", lb, 8'h00);
`endif
    run_frame(0, 0, 3, 1'b0, lb);
    bank[3] = 32'h0000_0300;
    run_frame(0, 5, -1, 1'b0, lb);
    run_frame(3, 0, -1, 1'b0, lb);

    // Abort mid-frame with reset during byte 12.
    base_l = launch_tot;
    @(negedge clk);
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    for (int c = 0; c < 5000 && (launch_tot - base_l) < 12; c++) @(negedge clk);
    check_val("abort_reached", 32'(launch_tot - base_l), 32'd12);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_tx_start", tx_start, 1'b0);
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_freeze", cnt_freeze, 1'b0);
    aborted_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) aborted_done++;
    end
    check_val("abort_no_done", aborted_done, 0);
    check_val("abort_no_launch", launch_tot - base_l, 12);
    run_frame(0, 0, -1, 1'b0, lb);

    run_frame(0, 0, -1, 1'b1, lb);

`ifdef PERF_DUMP_CKSUM_EN
    for (int k = 0; k < 16; k++) bank[k] = 32'h0;
    bank[0] = 32'h1234_5678;
    run_frame(0, 0, -1, 1'b0, lb);
    check_val("cksum_single", lb, 8'h08);
`endif

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 16; k++) bank[k] = $urandom;
      busy_len = int'($urandom_range(1, 12));
      run_frame((r == 2) ? int'($urandom_range(1, 30)) : 0, 0, -1, 1'b0, lb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
